// File: rtl/calc_result_display_if.sv
// Handshake/result bundle between the calculator datapath and the result display stage.
// The master drives the result strobe; the slave returns status and the scanned display lines.
interface calc_result_display_if;
    logic       load;
    logic [8:0] result;
    logic       err;
    logic       busy;
    logic       valid;
    logic [3:0] an;
    logic [6:0] seg;

    modport master (output load, output result, output err,
                    input busy, input valid, input an, input seg);
    modport slave  (input load, input result, input err,
                    output busy, output valid, output an, output seg);
endinterface

// File: rtl/calc_result_display.sv
// Captures a signed 9-bit calculator result, converts its magnitude to BCD by double-dabble
// and scans it onto a 4-digit multiplexed 7-segment display (sign, hundreds, tens, units).
module calc_result_display #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    calc_result_display_if.slave bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [3:0] SYM_MINUS = 4'd10;
    localparam logic [3:0] SYM_E     = 4'd11;
    localparam logic [3:0] SYM_R     = 4'd12;
    localparam logic [3:0] SYM_BLANK = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic            sign_r, err_r, valid_r;
    logic [8:0]      mag_r;
    logic [8:0]      mag_s;
    logic [11:0]     bcd_r;
    logic [3:0]      cnt_r;
    logic            disp_sign_r, disp_err_r;
    logic [3:0]      disp_d2_r, disp_d1_r, disp_d0_r;
    logic [CW-1:0]   refresh_r;
    logic [1:0]      digit_r;
    logic [3:0]      sym_s;

    // One double-dabble step: bias nibbles >= 5 by 3, then shift in the next magnitude bit.
    function automatic logic [11:0] dd_step(input logic [11:0] b, input logic in_bit);
        logic [11:0] a;
        a = b;
        for (int i = 0; i < 3; i++) begin
            if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
            else                     a[4*i +: 4] = a[4*i +: 4];
        end
        return {a[10:0], in_bit};
    endfunction

    // Active-low {g..a} pattern for a digit or display symbol.
    function automatic logic [6:0] seg_code(input logic [3:0] s);
        case (s)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'd10:   return 7'b0111111;
            4'd11:   return 7'b0000110;
            4'd12:   return 7'b0101111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Negation in 9 bits maps -256 (9'h100) onto magnitude 256 without overflow.
    assign mag_s = bus.result[8] ? (9'd0 - bus.result) : bus.result;

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= S_IDLE;
        else       state_r <= state_s;
    end

    // Next-state logic; loads arriving outside IDLE are ignored.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.load) state_s = S_CONVERT;
                else          state_s = S_IDLE;
            end
            S_CONVERT: begin
                if (cnt_r == 4'd8) state_s = S_COMMIT;
                else               state_s = S_CONVERT;
            end
            S_COMMIT: state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // Capture, conversion and atomic commit into the display registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_r      <= 1'b0;
            err_r       <= 1'b0;
            mag_r       <= 9'd0;
            bcd_r       <= 12'd0;
            cnt_r       <= 4'd0;
            valid_r     <= 1'b0;
            disp_sign_r <= 1'b0;
            disp_err_r  <= 1'b0;
            disp_d2_r   <= 4'd0;
            disp_d1_r   <= 4'd0;
            disp_d0_r   <= 4'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.load) begin
                        sign_r <= bus.result[8];
                        err_r  <= bus.err;
                        mag_r  <= mag_s;
                        bcd_r  <= 12'd0;
                        cnt_r  <= 4'd0;
                    end
                end
                S_CONVERT: begin
                    bcd_r <= dd_step(bcd_r, mag_r[8]);
                    mag_r <= {mag_r[7:0], 1'b0};
                    cnt_r <= cnt_r + 4'd1;
                end
                S_COMMIT: begin
                    disp_sign_r <= sign_r;
                    disp_err_r  <= err_r;
                    disp_d2_r   <= bcd_r[11:8];
                    disp_d1_r   <= bcd_r[7:4];
                    disp_d0_r   <= bcd_r[3:0];
                    valid_r     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Free-running digit scan, independent of the conversion sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_r <= '0;
            digit_r   <= 2'd0;
        end else if (refresh_r == CW'(REFRESH_DIV - 1)) begin
            refresh_r <= '0;
            digit_r   <= digit_r + 2'd1;
        end else begin
            refresh_r <= refresh_r + CW'(1);
        end
    end

    // Symbol for the active digit, with error text and leading-zero blanking.
    always_comb begin
        sym_s = SYM_BLANK;
        if (disp_err_r) begin
            case (digit_r)
                2'd0:    sym_s = SYM_R;
                2'd1:    sym_s = SYM_R;
                2'd2:    sym_s = SYM_E;
                default: sym_s = SYM_BLANK;
            endcase
        end else begin
            case (digit_r)
                2'd0:    sym_s = disp_d0_r;
                2'd1:    sym_s = (disp_d2_r == 4'd0 && disp_d1_r == 4'd0) ? SYM_BLANK : disp_d1_r;
                2'd2:    sym_s = (disp_d2_r == 4'd0) ? SYM_BLANK : disp_d2_r;
                default: sym_s = disp_sign_r ? SYM_MINUS : SYM_BLANK;
            endcase
        end
    end

    assign bus.busy  = (state_r != S_IDLE);
    assign bus.valid = valid_r;
    assign bus.an    = ~(4'b0001 << digit_r);
    assign bus.seg   = SEG_ACTIVE_LOW ? seg_code(sym_s) : ~seg_code(sym_s);
endmodule

// File: tb/tb_calc_result_display.sv
// Randomised self-checking bench for calc_result_display: an arithmetic reference model
// predicts the four displayed symbols and the bench compares every scanned digit against it.
module tb_calc_result_display;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    calc_result_display_if bus ();

    calc_result_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected active-low pattern at display position pos for a signed value / error flag.
    function automatic logic [6:0] exp_seg(input int val, input bit e, input int pos);
        logic [6:0] digits [10];
        logic [6:0] blank, minus, e_code, r_code;
        int mag, h, t, u;
        digits = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        blank  = 7'b1111111;
        minus  = 7'b0111111;
        e_code = 7'b0000110;
        r_code = 7'b0101111;
        if (e) begin
            if (pos == 3) return blank;
            if (pos == 2) return e_code;
            return r_code;
        end
        mag = (val < 0) ? -val : val;
        h = mag / 100;
        t = (mag / 10) % 10;
        u = mag % 10;
        case (pos)
            3:       return (val < 0) ? minus : blank;
            2:       return (h == 0) ? blank : digits[h];
            1:       return (h == 0 && t == 0) ? blank : digits[t];
            default: return digits[u];
        endcase
    endfunction

    // Observe one full scan (16 clocks) and compare every active digit with the model.
    task automatic check_display(input string name, input int val, input bit e);
        int pos;
        logic [6:0] want;
        for (int k = 0; k < 16; k++) begin
            pos = -1;
            for (int p = 0; p < 4; p++) if (bus.an === ~(4'b0001 << p)) pos = p;
            n_checks++;
            if (pos < 0) begin
                n_fail++;
                $display("FAIL %s an_onehot: got %b, required one-hot active-low", name, bus.an);
            end else begin
                want = exp_seg(val, e, pos);
                n_checks++;
                if (bus.seg !== want) begin
                    n_fail++;
                    $display("FAIL %s seg[digit %0d]: got %b, required %b", name, pos, bus.seg, want);
                end
            end
            @(negedge clk);
        end
    endtask

    // Pulse load for one cycle and count the busy cycles that follow (ends at cycle N+11).
    task automatic do_load(input logic [8:0] r, input logic e, output int busy_cnt);
        bus.load = 1'b1; bus.result = r; bus.err = e;
        @(posedge clk);
        @(negedge clk);
        bus.load = 1'b0;
        busy_cnt = 0;
        while (bus.busy === 1'b1 && busy_cnt < 40) begin
            busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_busy(input string name, input int got);
        n_checks++;
        if (got !== 10) begin
            n_fail++;
            $display("FAIL %s busy_width: got %0d cycles, required 10", name, got);
        end
    endtask

    task automatic check_valid(input string name, input logic want);
        n_checks++;
        if (bus.valid !== want) begin
            n_fail++;
            $display("FAIL %s valid: got %b, required %b", name, bus.valid, want);
        end
    endtask

    task automatic test_reset();
        logic [3:0] want_an;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset busy: got %b, required 0", bus.busy);
        end
        check_valid("reset", 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            want_an = ~(4'b0001 << ((k / 4) % 4));
            n_checks++;
            if (bus.an !== want_an) begin
                n_fail++;
                $display("FAIL reset scan_an[%0d]: got %b, required %b", k, bus.an, want_an);
            end
            @(negedge clk);
        end
        check_display("reset", 0, 1'b0);
    endtask

    task automatic test_basic();
        int bc;
        do_load(9'd123, 1'b0, bc);
        check_busy("basic", bc);
        check_valid("basic", 1'b1);
        check_display("basic", 123, 1'b0);
    endtask

    task automatic test_negative();
        int bc;
        do_load(9'h1F9, 1'b0, bc);
        check_busy("neg7", bc);
        check_display("neg7", -7, 1'b0);
        do_load(9'h100, 1'b0, bc);
        check_busy("neg256", bc);
        check_display("neg256", -256, 1'b0);
    endtask

    task automatic test_err();
        int bc;
        do_load(9'd45, 1'b1, bc);
        check_busy("err", bc);
        check_display("err", 45, 1'b1);
        do_load(9'd0, 1'b0, bc);
        check_display("zero", 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int bc;
        bus.load = 1'b1; bus.result = 9'd200; bus.err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.load = 1'b0;
        bc = 0;
        while (bus.busy === 1'b1 && bc < 40) begin
            bc++;
            if (bc == 3) begin
                bus.load = 1'b1; bus.result = 9'd5;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
        check_busy("b2b", bc);
        check_display("b2b", 200, 1'b0);
    endtask

    task automatic test_reset_mid();
        int bc;
        bus.load = 1'b1; bus.result = 9'd99; bus.err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.load = 1'b0;
        bc = 1;
        while (bc < 5) begin
            bc++;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid busy: got %b, required 0", bus.busy);
        end
        check_valid("reset_mid", 1'b0);
        check_display("reset_mid", 0, 1'b0);
        do_load(9'd99, 1'b0, bc);
        check_busy("after_reset", bc);
        check_valid("after_reset", 1'b1);
        check_display("after_reset", 99, 1'b0);
    endtask

    task automatic test_random();
        int bc;
        int val;
        logic [8:0] r;
        logic e;
        for (int n = 0; n < 20; n++) begin
            r   = 9'($urandom_range(0, 511));
            e   = ($urandom_range(0, 7) == 0);
            val = r[8] ? int'(r) - 512 : int'(r);
            do_load(r, e, bc);
            check_busy("random", bc);
            check_display("random", val, e);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset      = 1'b1;
        bus.load   = 1'b0;
        bus.result = 9'd0;
        bus.err    = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end
endmodule
